// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART TX FIFO push port among N requesters.
// Optional stall release: define UART_ARB_TIMEOUT_EN to free a grant after TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int          N         = 4,
    parameter logic [7:0]  EOM_CHAR  = 8'h0A,
    parameter int          MAX_BURST = 64,
    parameter int          TIMEOUT   = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*8-1:0] req_byte,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic [7:0]     uart_tx_byte,
    output logic           uart_transmit,
    input  logic           uart_tx_fifo_full,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_PUSH   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t        state_r;
    logic [IW-1:0] owner_r;
    logic [IW-1:0] rr_ptr_r;
    logic [7:0]    burst_cnt_r;

    logic [IW-1:0] pick_s;
    logic          pick_vld_s;
    logic [IW-1:0] cand_s;
    logic          owner_valid_s;
    logic [7:0]    owner_byte_s;
    logic          xfer_s;
    logic          release_s;
    logic          to_hit_s;

    // Round-robin search: walk from farthest to nearest after rr pointer so the nearest valid index wins.
    always_comb begin
        pick_s     = '0;
        pick_vld_s = 1'b0;
        cand_s     = '0;
        for (int k = N; k >= 1; k--) begin
            cand_s = IW'((int'(rr_ptr_r) + k) % N);
            if (req_valid[cand_s]) begin
                pick_s     = cand_s;
                pick_vld_s = 1'b1;
            end else begin
                pick_s     = pick_s;
                pick_vld_s = pick_vld_s;
            end
        end
    end

    assign owner_valid_s = req_valid[owner_r];
    assign owner_byte_s  = req_byte[{owner_r, 3'b000} +: 8];
    assign xfer_s        = (state_r == ST_LOCKED) && owner_valid_s && !uart_tx_fifo_full;
    assign release_s     = (uart_tx_byte == EOM_CHAR) || (burst_cnt_r == 8'(MAX_BURST));

    // Ready decode: only the owner, only in LOCKED, only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (state_r == ST_LOCKED) begin
            req_ready[owner_r] = !uart_tx_fifo_full;
        end else begin
            req_ready = '0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_r;
    logic          stall_s;

    assign stall_s  = (state_r == ST_LOCKED) && !owner_valid_s && !uart_tx_fifo_full;
    assign to_hit_s = stall_s && (to_cnt_r == TW'(TIMEOUT - 1));

    // Stall counter: counts owner-idle cycles in LOCKED, frozen while the FIFO is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_r <= '0;
        end else if ((state_r != ST_LOCKED) || xfer_s || to_hit_s) begin
            to_cnt_r <= '0;
        end else if (stall_s) begin
            to_cnt_r <= to_cnt_r + TW'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign to_hit_s = 1'b0;
`endif

    // Arbiter FSM with registered grant, push strobe, data and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            owner_r       <= '0;
            rr_ptr_r      <= IW'(N - 1);
            burst_cnt_r   <= 8'd0;
            grant         <= '0;
            uart_tx_byte  <= 8'h00;
            uart_transmit <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    uart_transmit <= 1'b0;
                    if (pick_vld_s) begin
                        owner_r     <= pick_s;
                        grant       <= {{(N-1){1'b0}}, 1'b1} << pick_s;
                        burst_cnt_r <= 8'd0;
                        state_r     <= ST_LOCKED;
                        busy        <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s) begin
                        uart_tx_byte  <= owner_byte_s;
                        burst_cnt_r   <= burst_cnt_r + 8'd1;
                        uart_transmit <= 1'b1;
                        state_r       <= ST_PUSH;
                    end else if (to_hit_s) begin
                        rr_ptr_r <= owner_r;
                        grant    <= '0;
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                ST_PUSH: begin
                    uart_transmit <= 1'b0;
                    state_r       <= ST_GAP;
                end
                ST_GAP: begin
                    uart_transmit <= 1'b0;
                    if (release_s) begin
                        rr_ptr_r <= owner_r;
                        grant    <= '0;
                        state_r  <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    grant         <= '0;
                    uart_transmit <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
